// File: rtl/siganfu_fire_controller.sv
// Fire-control sequencer for the siganfu gun: classifies a radar contact, builds a lock,
// commands fire against a round budget and backs off on gun overheat or gun-down.
module siganfu_fire_controller #(
    parameter int         IFF_TIMEOUT    = 20,
    parameter logic [3:0] LOCK_THRESHOLD = 4'd8,
    parameter int         LOCK_CYCLES    = 3,
    parameter int         BURST_ROUNDS   = 10,
    parameter int         ROUND_BUDGET   = 100,
    parameter logic [2:0] GUN_DOWN_STATE = 3'd7
) (
    input  logic       sysclk,
    input  logic       reboot,
    input  logic       radar_contact,
    input  logic       iff_valid,
    input  logic       iff_friend,
    input  logic [3:0] track_quality,
    input  logic       operator_arm,
    input  logic       auto_request,
    input  logic       burst_request,
    input  logic [2:0] gun_state,
    input  logic       gun_alert,
    input  logic       gun_fire_trigger,
    output logic       is_enemy,
    output logic       target_locked,
    output logic       fire_command,
    output logic       firing_mode,
    output logic [7:0] rounds_fired,
    output logic [2:0] ctrl_state,
    output logic       engagement_done
);

    typedef enum logic [2:0] {
        SCAN     = 3'd0,
        IDENTIFY = 3'd1,
        TRACK    = 3'd2,
        LOCKED   = 3'd3,
        ENGAGE   = 3'd4,
        HOLD     = 3'd5,
        CEASE    = 3'd6,
        FAULT    = 3'd7
    } state_t;

    localparam int IFF_W  = $clog2(IFF_TIMEOUT + 1);
    localparam int GOOD_W = $clog2(LOCK_CYCLES + 1);

    state_t            state_q, state_d;
    logic [IFF_W-1:0]  iff_cnt_q, iff_cnt_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic              mode_q, mode_d;
    logic [7:0]        rounds_d;
    logic [7:0]        budget;
    logic              budget_hit;
    logic              good_sample;

    // iff_valid is a single-cycle strobe; iff_friend is only looked at in the cycle it is high.
    always_comb begin
        budget      = mode_q ? 8'(ROUND_BUDGET) : 8'(BURST_ROUNDS);
        budget_hit  = (rounds_fired == budget);
        good_sample = (track_quality >= LOCK_THRESHOLD);

        state_d    = state_q;
        iff_cnt_d  = '0;
        good_cnt_d = '0;
        mode_d     = mode_q;
        rounds_d   = rounds_fired;

        // The count stops at the budget, which also keeps it below the 8-bit ceiling.
        if ((state_q == ENGAGE || state_q == HOLD) && gun_fire_trigger && rounds_fired < budget)
            rounds_d = rounds_fired + 8'd1;

        if (gun_state == GUN_DOWN_STATE) begin
            state_d = FAULT;
        end else if (state_q == FAULT) begin
            state_d = FAULT;
        end else if (!radar_contact) begin
            if (state_q inside {LOCKED, ENGAGE, HOLD})
                state_d = CEASE;
            else
                state_d = SCAN;
        end else begin
            case (state_q)
                SCAN: state_d = IDENTIFY;
                IDENTIFY: begin
                    if (iff_valid)
                        state_d = iff_friend ? SCAN : TRACK;
                    else if (iff_cnt_q == IFF_W'(IFF_TIMEOUT - 1))
                        state_d = TRACK;
                    else
                        iff_cnt_d = iff_cnt_q + IFF_W'(1);
                end
                TRACK: begin
                    if (good_sample) begin
                        if (good_cnt_q == GOOD_W'(LOCK_CYCLES - 1))
                            state_d = LOCKED;
                        else
                            good_cnt_d = good_cnt_q + GOOD_W'(1);
                    end
                end
                LOCKED: begin
                    if (operator_arm && (auto_request || burst_request)) begin
                        state_d  = ENGAGE;
                        mode_d   = auto_request;
                        rounds_d = '0;
                    end
                end
                ENGAGE: begin
                    if (budget_hit || !operator_arm)
                        state_d = CEASE;
                    else if (gun_alert)
                        state_d = HOLD;
                end
                HOLD: begin
                    if (!operator_arm)
                        state_d = CEASE;
                    else if (!gun_alert)
                        state_d = ENGAGE;
                end
                CEASE:   state_d = SCAN;
                default: state_d = state_q;
            endcase
        end
    end

    // Outputs are decoded from the next state so they register on the same edge as the state.
    always_ff @(posedge sysclk or negedge reboot) begin
        if (!reboot) begin
            state_q         <= SCAN;
            iff_cnt_q       <= '0;
            good_cnt_q      <= '0;
            mode_q          <= 1'b0;
            rounds_fired    <= '0;
            is_enemy        <= 1'b0;
            target_locked   <= 1'b0;
            fire_command    <= 1'b0;
            firing_mode     <= 1'b0;
            engagement_done <= 1'b0;
        end else begin
            state_q         <= state_d;
            iff_cnt_q       <= iff_cnt_d;
            good_cnt_q      <= good_cnt_d;
            mode_q          <= mode_d;
            rounds_fired    <= rounds_d;
            is_enemy        <= state_d inside {TRACK, LOCKED, ENGAGE, HOLD};
            target_locked   <= state_d inside {LOCKED, ENGAGE, HOLD};
            fire_command    <= (state_d == ENGAGE);
            firing_mode     <= (state_d inside {ENGAGE, HOLD}) && mode_d;
            engagement_done <= (state_d == CEASE);
        end
    end

    assign ctrl_state = state_q;

endmodule

// File: tb/tb_siganfu_fire_controller.sv
// Bench for siganfu_fire_controller: directed engagement scenarios followed by random
// sensor/operator/gun traffic, all compared cycle by cycle against a rule-level model.
module tb_siganfu_fire_controller;

    localparam int IFF_TIMEOUT  = 20;
    localparam int LOCK_THRESH  = 8;
    localparam int LOCK_CYCLES  = 3;
    localparam int BURST_ROUNDS = 10;
    localparam int ROUND_BUDGET = 100;
    localparam int GUN_DOWN     = 7;

    localparam int S_SCAN = 0, S_IDENT = 1, S_TRACK = 2, S_LOCKED = 3;
    localparam int S_ENGAGE = 4, S_HOLD = 5, S_CEASE = 6, S_FAULT = 7;

    logic       sysclk;
    logic       reboot;
    logic       radar_contact;
    logic       iff_valid;
    logic       iff_friend;
    logic [3:0] track_quality;
    logic       operator_arm;
    logic       auto_request;
    logic       burst_request;
    logic [2:0] gun_state;
    logic       gun_alert;
    logic       gun_fire_trigger;
    logic       is_enemy;
    logic       target_locked;
    logic       fire_command;
    logic       firing_mode;
    logic [7:0] rounds_fired;
    logic [2:0] ctrl_state;
    logic       engagement_done;

    siganfu_fire_controller dut (
        .sysclk          (sysclk),
        .reboot          (reboot),
        .radar_contact   (radar_contact),
        .iff_valid       (iff_valid),
        .iff_friend      (iff_friend),
        .track_quality   (track_quality),
        .operator_arm    (operator_arm),
        .auto_request    (auto_request),
        .burst_request   (burst_request),
        .gun_state       (gun_state),
        .gun_alert       (gun_alert),
        .gun_fire_trigger(gun_fire_trigger),
        .is_enemy        (is_enemy),
        .target_locked   (target_locked),
        .fire_command    (fire_command),
        .firing_mode     (firing_mode),
        .rounds_fired    (rounds_fired),
        .ctrl_state      (ctrl_state),
        .engagement_done (engagement_done)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: current phase, IFF wait, good-sample run, rounds and engagement mode.
    int m_st, m_wait, m_good, m_rounds;
    bit m_auto;
    bit enemy_tab  [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
    bit locked_tab [8] = '{0, 0, 0, 1, 1, 1, 0, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = S_SCAN; m_wait = 0; m_good = 0; m_rounds = 0; m_auto = 1'b0;
    endtask

    task automatic model_step();
        int st, rnd, budget, wait_n, good_n;
        bit am;
        if (!reboot) begin
            model_reset();
            return;
        end
        budget = m_auto ? ROUND_BUDGET : BURST_ROUNDS;
        st = m_st; rnd = m_rounds; am = m_auto; wait_n = 0; good_n = 0;
        if ((m_st == S_ENGAGE || m_st == S_HOLD) && gun_fire_trigger && m_rounds < budget)
            rnd = m_rounds + 1;
        if (int'(gun_state) == GUN_DOWN) st = S_FAULT;
        else if (m_st == S_FAULT) st = S_FAULT;
        else if (!radar_contact) st = (m_st >= S_LOCKED && m_st <= S_HOLD) ? S_CEASE : S_SCAN;
        else begin
            case (m_st)
                S_SCAN:  st = S_IDENT;
                S_IDENT: begin
                    if (iff_valid) st = iff_friend ? S_SCAN : S_TRACK;
                    else if (m_wait == IFF_TIMEOUT - 1) st = S_TRACK;
                    else wait_n = m_wait + 1;
                end
                S_TRACK: begin
                    if (int'(track_quality) >= LOCK_THRESH) begin
                        if (m_good + 1 == LOCK_CYCLES) st = S_LOCKED;
                        else good_n = m_good + 1;
                    end
                end
                S_LOCKED: begin
                    if (operator_arm && (auto_request || burst_request)) begin
                        st = S_ENGAGE; am = auto_request; rnd = 0;
                    end
                end
                S_ENGAGE: begin
                    if (m_rounds == budget || !operator_arm) st = S_CEASE;
                    else if (gun_alert) st = S_HOLD;
                end
                S_HOLD: begin
                    if (!operator_arm) st = S_CEASE;
                    else if (!gun_alert) st = S_ENGAGE;
                end
                default: st = S_SCAN;
            endcase
        end
        m_st = st; m_rounds = rnd; m_auto = am; m_wait = wait_n; m_good = good_n;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".ctrl_state"},      32'(ctrl_state),      32'(m_st));
        chk({tag, ".is_enemy"},        32'(is_enemy),        32'(enemy_tab[m_st]));
        chk({tag, ".target_locked"},   32'(target_locked),   32'(locked_tab[m_st]));
        chk({tag, ".fire_command"},    32'(fire_command),    32'(m_st == S_ENGAGE));
        chk({tag, ".firing_mode"},     32'(firing_mode),     32'((m_st == S_ENGAGE || m_st == S_HOLD) && m_auto));
        chk({tag, ".rounds_fired"},    32'(rounds_fired),    32'(m_rounds));
        chk({tag, ".engagement_done"}, 32'(engagement_done), 32'(m_st == S_CEASE));
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge sysclk);
        #1;
        check_outputs(tag);
    endtask

    task automatic drv(input logic rc, input logic iv, input logic ifr, input logic [3:0] q,
                       input logic arm, input logic au, input logic bu, input logic [2:0] gs,
                       input logic al, input logic tr);
        radar_contact = rc; iff_valid = iv; iff_friend = ifr; track_quality = q;
        operator_arm = arm; auto_request = au; burst_request = bu; gun_state = gs;
        gun_alert = al; gun_fire_trigger = tr;
    endtask

    // From SCAN: contact, hostile reply, three good samples, then arm in the chosen mode.
    task automatic to_engage(input logic au);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("eng_contact");
        drv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); step("eng_iff");
        drv(1, 0, 0, 9, 0, 0, 0, 0, 0, 0); repeat (3) step("eng_track");
        drv(1, 0, 0, 9, 1, au, !au, 0, 0, 0); step("eng_arm");
        chk("to_engage.ctrl", 32'(ctrl_state), 32'(S_ENGAGE));
    endtask

    initial begin
        reboot = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (3) step("reset");
        chk("reset.ctrl", 32'(ctrl_state), 32'(0));
        chk("reset.rounds", 32'(rounds_fired), 32'(0));
        reboot = 1'b1;

        // Hostile auto engagement to the 100-round budget.
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("s1_contact");
        chk("s1.identify", 32'(ctrl_state), 32'(S_IDENT));
        drv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); step("s1_hostile");
        chk("s1.is_enemy", 32'(is_enemy), 32'(1));
        drv(1, 0, 0, 9, 0, 0, 0, 0, 0, 0);
        repeat (2) step("s1_track");
        chk("s1.not_locked_yet", 32'(target_locked), 32'(0));
        step("s1_track");
        chk("s1.locked", 32'(target_locked), 32'(1));
        drv(1, 0, 0, 9, 1, 1, 0, 0, 0, 0); step("s1_arm");
        chk("s1.fire", 32'(fire_command), 32'(1));
        chk("s1.auto", 32'(firing_mode), 32'(1));
        drv(1, 0, 0, 9, 1, 1, 0, 0, 0, 1);
        repeat (100) step("s1_fire");
        chk("s1.rounds100", 32'(rounds_fired), 32'(100));
        step("s1_cease");
        chk("s1.cease", 32'(ctrl_state), 32'(S_CEASE));
        chk("s1.done", 32'(engagement_done), 32'(1));
        chk("s1.rounds_held", 32'(rounds_fired), 32'(100));
        step("s1_scan");
        chk("s1.scan", 32'(ctrl_state), 32'(S_SCAN));
        chk("s1.done_pulse", 32'(engagement_done), 32'(0));

        // Friendly reply returns to SCAN without ever flagging an enemy.
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("s2_contact");
        drv(1, 1, 1, 0, 0, 0, 0, 0, 0, 0); step("s2_friend");
        chk("s2.scan", 32'(ctrl_state), 32'(S_SCAN));
        chk("s2.no_enemy", 32'(is_enemy), 32'(0));
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("s2_idle");

        // IFF silence times out into TRACK; a bad sample restarts the lock run.
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("s3_contact");
        repeat (19) step("s3_wait");
        chk("s3.still_identify", 32'(ctrl_state), 32'(S_IDENT));
        step("s3_timeout");
        chk("s3.track", 32'(ctrl_state), 32'(S_TRACK));
        begin
            logic [3:0] qseq [6] = '{4'd9, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};
            for (int i = 0; i < 6; i++) begin
                drv(1, 0, 0, qseq[i], 0, 0, 0, 0, 0, 0);
                step("s3_quality");
                chk("s3.lock_seq", 32'(ctrl_state), 32'((i == 5) ? S_LOCKED : S_TRACK));
            end
        end

        // Burst with an overheat pause; rounds survive HOLD and stop at 10.
        drv(1, 0, 0, 0, 1, 0, 1, 0, 0, 0); step("s4_arm");
        chk("s4.rounds_cleared", 32'(rounds_fired), 32'(0));
        chk("s4.burst_mode", 32'(firing_mode), 32'(0));
        drv(1, 0, 0, 0, 1, 0, 1, 0, 0, 1); repeat (4) step("s4_fire");
        drv(1, 0, 0, 0, 1, 0, 1, 0, 1, 0); step("s4_alert");
        chk("s4.hold", 32'(ctrl_state), 32'(S_HOLD));
        chk("s4.hold_no_fire", 32'(fire_command), 32'(0));
        chk("s4.hold_rounds", 32'(rounds_fired), 32'(4));
        chk("s4.hold_locked", 32'(target_locked), 32'(1));
        step("s4_hold");
        drv(1, 0, 0, 0, 1, 0, 1, 0, 0, 0); step("s4_resume");
        chk("s4.resume", 32'(fire_command), 32'(1));
        drv(1, 0, 0, 0, 1, 0, 1, 0, 0, 1); repeat (6) step("s4_fire2");
        chk("s4.rounds10", 32'(rounds_fired), 32'(10));
        step("s4_cease");
        chk("s4.cease_done", 32'(engagement_done), 32'(1));
        chk("s4.cease_rounds", 32'(rounds_fired), 32'(10));
        step("s4_scan");

        // Gun down mid-engagement is sticky until reboot.
        to_engage(1);
        drv(1, 0, 0, 9, 1, 1, 0, 3'd7, 0, 1); step("s5_down");
        chk("s5.fault", 32'(ctrl_state), 32'(S_FAULT));
        chk("s5.fault_fire", 32'(fire_command), 32'(0));
        chk("s5.fault_enemy", 32'(is_enemy), 32'(0));
        drv(1, 0, 0, 9, 1, 1, 0, 0, 0, 0); repeat (5) step("s5_sticky");
        chk("s5.sticky", 32'(ctrl_state), 32'(S_FAULT));
        #2 reboot = 1'b0;
        #1 model_reset();
        check_outputs("s5_reboot");
        step("s5_reboot_hold");
        reboot = 1'b1;

        // Asynchronous reset in the middle of firing.
        to_engage(0);
        drv(1, 0, 0, 9, 1, 0, 1, 0, 0, 1); repeat (3) step("s6_fire");
        #2 reboot = 1'b0;
        #1 model_reset();
        chk("s6.fire_dropped", 32'(fire_command), 32'(0));
        check_outputs("s6_async");
        repeat (2) step("s6_hold");
        chk("s6.no_done", 32'(engagement_done), 32'(0));
        reboot = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            reboot = ($urandom_range(0, 149) != 0);
            drv($urandom_range(0, 19) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                4'($urandom_range(5, 15)), $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1,
                ($urandom_range(0, 399) == 0) ? 3'd7 : 3'($urandom_range(0, 6)),
                $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
